// File: rtl/volume_mix_sequencer_if.sv
// volume_mix_sequencer_if
//   Output stream of the volume mix sequencer: one saturated mix sample per
//   frame, offered with a valid/ready handshake.
//   Signals:
//     mix_out    16-bit signed mix sample (stable while mix_valid is high)
//     mix_valid  mix_out holds a sample that has not been accepted yet
//     mix_ready  downstream accepts mix_out when high together with mix_valid
//   Modports:
//     master  the sequencer (drives mix_out/mix_valid, observes mix_ready)
//     slave   the downstream consumer
interface volume_mix_sequencer_if;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic        mix_ready;

  modport master (output mix_out, output mix_valid, input mix_ready);
  modport slave  (input mix_out, input mix_valid, output mix_ready);
endinterface

// File: rtl/volume_mix_sequencer.sv
// volume_mix_sequencer
//   Shares one external volume_adjust scaler across NUM_VOICES voices. On an
//   accepted frame_start the voice samples are latched and the per-voice
//   volumes updated; each voice is then pushed through the scaler on its own
//   cycle, the scaled results are summed, and the sum is clamped to a 16-bit
//   signed mix sample offered on the mix_if stream.
//   Optional feature macro: VOLUME_RAMP_EN
//     defined   - each accepted frame moves every volume one step toward its target
//     undefined - each accepted frame loads the target volumes directly
//   Ports:
//     clk, rst        clock and synchronous active-high reset
//     frame_start     one-cycle pulse starting a frame (ignored while busy)
//     voice_samples   packed signed samples, voice i at [16*i +: 16]
//     target_volume   packed target volumes, voice i at [VOLUME_BITS*i +: VOLUME_BITS]
//     scaler_sample   sample presented to the external scaler
//     scaler_volume   volume presented to the external scaler
//     scaler_result   combinational result returned by the external scaler
//     mix_if          master side of the mix output stream
//     busy            high whenever a frame is in progress
//     frame_overrun   one-cycle pulse when frame_start arrives while busy
module volume_mix_sequencer #(
  parameter int NUM_VOICES  = 4,
  parameter int VOLUME_BITS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_start,
  input  logic [NUM_VOICES*16-1:0]          voice_samples,
  input  logic [NUM_VOICES*VOLUME_BITS-1:0] target_volume,
  output logic [15:0]                       scaler_sample,
  output logic [VOLUME_BITS-1:0]            scaler_volume,
  input  logic [15:0]                       scaler_result,
  volume_mix_sequencer_if.master            mix_if,
  output logic                              busy,
  output logic                              frame_overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = 16 + $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [1:0] {IDLE, SCALE, SAT, HOLD} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]              samp_q [NUM_VOICES];
  logic [15:0]              samp_d [NUM_VOICES];
  logic [VOLUME_BITS-1:0]   cur_vol_q [NUM_VOICES];
  logic [VOLUME_BITS-1:0]   cur_vol_d [NUM_VOICES];
  logic [15:0]              mix_out_q, mix_out_d;
  logic                     mix_valid_q, mix_valid_d;
  logic                     frame_overrun_q, frame_overrun_d;

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      acc_q           <= '0;
      mix_out_q       <= '0;
      mix_valid_q     <= 1'b0;
      frame_overrun_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        samp_q[i]    <= '0;
        cur_vol_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      acc_q           <= acc_d;
      mix_out_q       <= mix_out_d;
      mix_valid_q     <= mix_valid_d;
      frame_overrun_q <= frame_overrun_d;
      samp_q          <= samp_d;
      cur_vol_q       <= cur_vol_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = SCALE;
      SCALE:   if (idx_q == LAST_IDX) state_d = SAT;
      SAT:     state_d = HOLD;
      HOLD:    if (mix_valid_q && mix_if.mix_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs. The scaler is only driven in SCALE so that it sees
  // zeros between frames.
  always_comb begin
    idx_d           = idx_q;
    acc_d           = acc_q;
    samp_d          = samp_q;
    cur_vol_d       = cur_vol_q;
    mix_out_d       = mix_out_q;
    mix_valid_d     = mix_valid_q;
    scaler_sample   = '0;
    scaler_volume   = '0;
    frame_overrun_d = frame_start && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          acc_d = '0;
          idx_d = '0;
          for (int i = 0; i < NUM_VOICES; i++) begin
            samp_d[i] = voice_samples[16*i +: 16];
`ifdef VOLUME_RAMP_EN
            // Targets are themselves in range, so stepping toward one can
            // never wrap past 0 or full scale.
            if (cur_vol_q[i] < target_volume[VOLUME_BITS*i +: VOLUME_BITS])
              cur_vol_d[i] = cur_vol_q[i] + VOLUME_BITS'(1);
            else if (cur_vol_q[i] > target_volume[VOLUME_BITS*i +: VOLUME_BITS])
              cur_vol_d[i] = cur_vol_q[i] - VOLUME_BITS'(1);
`else
            cur_vol_d[i] = target_volume[VOLUME_BITS*i +: VOLUME_BITS];
`endif
          end
        end
      end
      SCALE: begin
        scaler_sample = samp_q[idx_q];
        scaler_volume = cur_vol_q[idx_q];
        acc_d = acc_q + {{(ACC_W-16){scaler_result[15]}}, scaler_result};
        idx_d = idx_q + IDX_W'(1);
      end
      SAT: begin
        if (acc_q > SAT_MAX)
          mix_out_d = 16'h7fff;
        else if (acc_q < SAT_MIN)
          mix_out_d = 16'h8000;
        else
          mix_out_d = acc_q[15:0];
        mix_valid_d = 1'b1;
      end
      HOLD: begin
        if (mix_valid_q && mix_if.mix_ready) mix_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign mix_if.mix_out   = mix_out_q;
  assign mix_if.mix_valid = mix_valid_q;
  assign busy             = (state_q != IDLE);
  assign frame_overrun    = frame_overrun_q;

endmodule
